// File: rtl/aes_cbc_pkcs7_pad.sv
// Framing stage ahead of the AES-256-CBC core: forwards key+IV and appends PKCS#7 padding to encrypt payloads.
// Optional AES_PAD_DEC_CHECK_EN: zero-pads misaligned decrypt frames to a block boundary and raises sticky Len_err.
module aes_cbc_pkcs7_pad #(
    parameter int HDR_BYTES = 48,
    parameter int BLK_BYTES = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] S_axis_tdata,
    input  logic       S_axis_tkeep,
    input  logic       S_axis_tuser,
    input  logic       S_axis_tlast,
    input  logic       S_axis_tvalid,
    output logic       S_axis_tready,
    output logic [7:0] M_axis_tdata,
    output logic       M_axis_tkeep,
    output logic       M_axis_tuser,
    output logic       M_axis_tlast,
    output logic       M_axis_tvalid,
    input  logic       M_axis_tready
`ifdef AES_PAD_DEC_CHECK_EN
    ,
    output logic       Len_err
`endif
);
    localparam int HDR_W = $clog2(HDR_BYTES);
    localparam int BLK_W = $clog2(BLK_BYTES);
    localparam int PAD_W = BLK_W + 1;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [HDR_W-1:0] hdr_cnt_r, hdr_cnt_nxt_s;
    logic [BLK_W-1:0] blk_cnt_r, blk_cnt_nxt_s;
    logic [PAD_W-1:0] pad_cnt_r, pad_cnt_nxt_s;
    logic [PAD_W-1:0] pad_val_r, pad_val_nxt_s;
    logic             enc_r, enc_nxt_s;

    logic [7:0]       m_tdata_r;
    logic             m_tkeep_r, m_tuser_r, m_tlast_r, m_tvalid_r;

    logic             slice_free_s, s_ready_s, s_acc_s, enc_cur_s, pad_last_s;
    logic             load_s, load_last_s;
    logic [7:0]       load_data_s, pad_byte_s;
    logic [BLK_W-1:0] blk_inc_s;
    logic [PAD_W-1:0] tail_pad_s;
    logic             unused_tkeep_s;
`ifdef AES_PAD_DEC_CHECK_EN
    logic             err_set_s;
    logic             len_err_r;
`endif

    assign unused_tkeep_s = S_axis_tkeep;

    assign slice_free_s = !m_tvalid_r || M_axis_tready;
    assign s_ready_s    = (state_r != ST_PAD) && slice_free_s;
    assign s_acc_s      = S_axis_tvalid && s_ready_s;
    // The first header byte selects the direction; the registered copy is valid only from the next beat on.
    assign enc_cur_s    = (state_r == ST_HDR && hdr_cnt_r == {HDR_W{1'b0}}) ? S_axis_tuser : enc_r;
    assign blk_inc_s    = blk_cnt_r + BLK_W'(1);
    assign tail_pad_s   = (blk_inc_s == {BLK_W{1'b0}}) ? PAD_W'(BLK_BYTES)
                                                       : PAD_W'(BLK_BYTES) - PAD_W'(blk_inc_s);
    assign pad_last_s   = (pad_cnt_r == pad_val_r - PAD_W'(1));
    assign pad_byte_s   = enc_r ? {{(8-PAD_W){1'b0}}, pad_val_r} : 8'h00;

    // Next-state, counter updates and output slice load selection.
    always_comb begin
        state_nxt_s   = state_r;
        hdr_cnt_nxt_s = hdr_cnt_r;
        blk_cnt_nxt_s = blk_cnt_r;
        pad_cnt_nxt_s = pad_cnt_r;
        pad_val_nxt_s = pad_val_r;
        enc_nxt_s     = enc_r;
        load_s        = 1'b0;
        load_data_s   = S_axis_tdata;
        load_last_s   = 1'b0;
`ifdef AES_PAD_DEC_CHECK_EN
        err_set_s     = 1'b0;
`endif
        case (state_r)
            ST_HDR: begin
                if (s_acc_s) begin
                    load_s    = 1'b1;
                    enc_nxt_s = enc_cur_s;
                    if (hdr_cnt_r == HDR_W'(HDR_BYTES - 1)) begin
                        hdr_cnt_nxt_s = {HDR_W{1'b0}};
                        blk_cnt_nxt_s = {BLK_W{1'b0}};
                        if (!S_axis_tlast) begin
                            state_nxt_s = ST_DATA;
                        end else if (enc_cur_s) begin
                            state_nxt_s   = ST_PAD;
                            pad_val_nxt_s = PAD_W'(BLK_BYTES);
                            pad_cnt_nxt_s = {PAD_W{1'b0}};
                        end else begin
                            load_last_s = 1'b1;
                            state_nxt_s = ST_HDR;
                        end
                    end else begin
                        hdr_cnt_nxt_s = hdr_cnt_r + HDR_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (s_acc_s) begin
                    load_s        = 1'b1;
                    blk_cnt_nxt_s = blk_inc_s;
                    if (!S_axis_tlast) begin
                        state_nxt_s = ST_DATA;
                    end else if (enc_r) begin
                        state_nxt_s   = ST_PAD;
                        pad_val_nxt_s = tail_pad_s;
                        pad_cnt_nxt_s = {PAD_W{1'b0}};
`ifdef AES_PAD_DEC_CHECK_EN
                    end else if (blk_inc_s != {BLK_W{1'b0}}) begin
                        state_nxt_s   = ST_PAD;
                        pad_val_nxt_s = tail_pad_s;
                        pad_cnt_nxt_s = {PAD_W{1'b0}};
                        err_set_s     = 1'b1;
`endif
                    end else begin
                        load_last_s = 1'b1;
                        state_nxt_s = ST_HDR;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAD: begin
                if (slice_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = pad_byte_s;
                    if (pad_last_s) begin
                        load_last_s   = 1'b1;
                        pad_cnt_nxt_s = {PAD_W{1'b0}};
                        state_nxt_s   = ST_HDR;
                    end else begin
                        pad_cnt_nxt_s = pad_cnt_r + PAD_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            default: begin
                state_nxt_s = ST_HDR;
            end
        endcase
    end

    // FSM state and frame counters.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r   <= ST_HDR;
            hdr_cnt_r <= {HDR_W{1'b0}};
            blk_cnt_r <= {BLK_W{1'b0}};
            pad_cnt_r <= {PAD_W{1'b0}};
            pad_val_r <= {PAD_W{1'b0}};
            enc_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            hdr_cnt_r <= hdr_cnt_nxt_s;
            blk_cnt_r <= blk_cnt_nxt_s;
            pad_cnt_r <= pad_cnt_nxt_s;
            pad_val_r <= pad_val_nxt_s;
            enc_r     <= enc_nxt_s;
        end
    end

    // Output register slice: loads when empty or draining, otherwise holds every field.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 8'h00;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
            m_tkeep_r  <= 1'b0;
        end else if (load_s) begin
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= load_data_s;
            m_tlast_r  <= load_last_s;
            m_tuser_r  <= enc_cur_s;
            m_tkeep_r  <= 1'b1;
        end else if (M_axis_tready) begin
            m_tvalid_r <= 1'b0;
        end
    end

`ifdef AES_PAD_DEC_CHECK_EN
    // Sticky length-error flag, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            len_err_r <= 1'b0;
        end else if (err_set_s) begin
            len_err_r <= 1'b1;
        end
    end

    assign Len_err = len_err_r;
`endif

    assign S_axis_tready = s_ready_s;
    assign M_axis_tdata  = m_tdata_r;
    assign M_axis_tkeep  = m_tkeep_r;
    assign M_axis_tuser  = m_tuser_r;
    assign M_axis_tlast  = m_tlast_r;
    assign M_axis_tvalid = m_tvalid_r;

endmodule

// File: tb/tb_aes_cbc_pkcs7_pad.sv
// Self-checking bench for aes_cbc_pkcs7_pad: table vectors, backpressure, mid-pad reset and random frames
// against a byte-stream reference model. Honours AES_PAD_DEC_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_aes_cbc_pkcs7_pad;
    localparam int HDR = 48;
    localparam int BLK = 16;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [7:0] S_axis_tdata;
    logic       S_axis_tkeep, S_axis_tuser, S_axis_tlast, S_axis_tvalid, S_axis_tready;
    logic [7:0] M_axis_tdata;
    logic       M_axis_tkeep, M_axis_tuser, M_axis_tlast, M_axis_tvalid, M_axis_tready;
`ifdef AES_PAD_DEC_CHECK_EN
    logic       Len_err;
`endif

    typedef struct packed { logic [7:0] d; logic l; logic u; } beat_t;
    typedef struct {
        bit         enc;
        int         plen;
        logic [7:0] pstart;
        int         exp_len;
        logic [7:0] exp_tail;
        int         mode;
        int         gap;
        bit         chk_rdy;
    } vec_t;

    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t cap_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    rst_hit = 1'b0;
    bit    err_model = 1'b0;

    aes_cbc_pkcs7_pad dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .S_axis_tdata (S_axis_tdata),
        .S_axis_tkeep (S_axis_tkeep),
        .S_axis_tuser (S_axis_tuser),
        .S_axis_tlast (S_axis_tlast),
        .S_axis_tvalid(S_axis_tvalid),
        .S_axis_tready(S_axis_tready),
        .M_axis_tdata (M_axis_tdata),
        .M_axis_tkeep (M_axis_tkeep),
        .M_axis_tuser (M_axis_tuser),
        .M_axis_tlast (M_axis_tlast),
        .M_axis_tvalid(M_axis_tvalid),
        .M_axis_tready(M_axis_tready)
`ifdef AES_PAD_DEC_CHECK_EN
        ,
        .Len_err      (Len_err)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: header and payload pass through, then padding to the next block boundary.
    task automatic add_frame(input bit enc, input int plen, input logic [7:0] pstart, input bit rnd);
        beat_t      b;
        int         npad;
        logic [7:0] pv;
        for (int i = 0; i < HDR; i++) begin
            b.d = rnd ? 8'($urandom) : 8'(i);
            b.u = (i == 0) ? enc : 1'($urandom);
            b.l = (i == HDR - 1) ? (plen == 0) : ($urandom_range(0, 9) == 0);
            in_q.push_back(b);
            exp_q.push_back('{d: b.d, l: 1'b0, u: enc});
        end
        for (int i = 0; i < plen; i++) begin
            b.d = rnd ? 8'($urandom) : pstart + 8'(i);
            b.u = 1'($urandom);
            b.l = (i == plen - 1);
            in_q.push_back(b);
            exp_q.push_back('{d: b.d, l: 1'b0, u: enc});
        end
        npad = 0;
        pv   = 8'h00;
        if (enc) begin
            npad = BLK - (plen % BLK);
            pv   = 8'(npad);
        end
`ifdef AES_PAD_DEC_CHECK_EN
        else if (plen % BLK != 0) begin
            npad      = BLK - (plen % BLK);
            err_model = 1'b1;
        end
`endif
        for (int i = 0; i < npad; i++) exp_q.push_back('{d: pv, l: 1'b0, u: enc});
        exp_q[exp_q.size() - 1].l = 1'b1;
    endtask

    // Drives in_q with optional gaps, applies the M_tready pattern and scores every output beat.
    task automatic run_stream(input int mode, input int gap_pct, input int rst_at, input bit chk_rdy);
        int          idx = 0, out_cnt = 0, drops = 0;
        bit          s_fire = 1'b0, stall = 1'b0, done = 1'b0, rst_exit = 1'b0;
        logic [11:0] held = 12'h0;
        beat_t       e;
        cap_q.delete();
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(posedge Clk);
            #1;
            if (s_fire) idx++;
            if (!(S_axis_tvalid && !s_fire)) begin
                if (idx < in_q.size() && $urandom_range(0, 99) >= gap_pct) begin
                    S_axis_tvalid = 1'b1;
                    S_axis_tdata  = in_q[idx].d;
                    S_axis_tlast  = in_q[idx].l;
                    S_axis_tuser  = in_q[idx].u;
                    S_axis_tkeep  = 1'b1;
                end else begin
                    S_axis_tvalid = 1'b0;
                end
            end
            case (mode)
                0:       M_axis_tready = 1'b1;
                1:       M_axis_tready = (cyc % 2 == 0);
                default: M_axis_tready = 1'($urandom);
            endcase
            @(negedge Clk);
            if (rst_at >= 0 && M_axis_tvalid && out_cnt == rst_at) begin
                Rst_n = 1'b0;
                S_axis_tvalid = 1'b0;
                rst_hit = 1'b1;
                rst_exit = 1'b1;
                done = 1'b1;
                in_q.delete();
                exp_q.delete();
            end else begin
                if (stall)
                    check("stall_hold", {M_axis_tvalid, M_axis_tdata, M_axis_tlast, M_axis_tuser, M_axis_tkeep}, held);
                if (chk_rdy && idx < in_q.size() && !S_axis_tready) drops++;
                s_fire = S_axis_tvalid && S_axis_tready;
                if (M_axis_tvalid && M_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(out_cnt), 32'(out_cnt + 1));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat[%0d]{d,last,user,keep}", out_cnt),
                              {M_axis_tdata, M_axis_tlast, M_axis_tuser, M_axis_tkeep}, {e.d, e.l, e.u, 1'b1});
                        cap_q.push_back('{d: M_axis_tdata, l: M_axis_tlast, u: M_axis_tuser});
                        out_cnt++;
                        if (exp_q.size() == 0) done = 1'b1;
                    end
                end
                stall = M_axis_tvalid && !M_axis_tready;
                held  = {M_axis_tvalid, M_axis_tdata, M_axis_tlast, M_axis_tuser, M_axis_tkeep};
            end
        end
        check("stream_done", 32'(done), 32'd1);
        if (chk_rdy) check("s_ready_drops", 32'(drops), 32'd0);
        if (!rst_exit) begin
            @(posedge Clk);
            #1;
            S_axis_tvalid = 1'b0;
        end
        in_q.delete();
        exp_q.delete();
    endtask

    vec_t       vt[5];
    int         ends[$];
    logic [7:0] bp_pad[3];
    int         bp_len[3];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0;
        S_axis_tvalid = 1'b0;
        S_axis_tdata = 8'h00;
        S_axis_tkeep = 1'b0;
        S_axis_tuser = 1'b0;
        S_axis_tlast = 1'b0;
        M_axis_tready = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_tvalid", 32'(M_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(M_axis_tdata), 32'd0);
        check("rst_tlast_tuser_tkeep", {M_axis_tlast, M_axis_tuser, M_axis_tkeep}, 32'd0);
`ifdef AES_PAD_DEC_CHECK_EN
        check("rst_len_err", 32'(Len_err), 32'd0);
`endif
        Rst_n = 1'b1;

        vt[0] = '{1'b1, 5,  8'h01, 64, 8'h0B, 0, 0,  1'b0};
        vt[1] = '{1'b1, 16, 8'hA0, 80, 8'h10, 0, 0,  1'b0};
        vt[2] = '{1'b1, 0,  8'h00, 64, 8'h10, 0, 0,  1'b0};
        vt[3] = '{1'b0, 32, 8'h40, 80, 8'h5F, 0, 0,  1'b1};
`ifdef AES_PAD_DEC_CHECK_EN
        vt[4] = '{1'b0, 20, 8'h60, 80, 8'h00, 2, 20, 1'b0};
`else
        vt[4] = '{1'b0, 20, 8'h60, 68, 8'h73, 2, 20, 1'b0};
`endif
        for (int v = 0; v < 5; v++) begin
            add_frame(vt[v].enc, vt[v].plen, vt[v].pstart, 1'b0);
            run_stream(vt[v].mode, vt[v].gap, -1, vt[v].chk_rdy);
            check($sformatf("vec%0d_len", v), 32'(cap_q.size()), 32'(vt[v].exp_len));
            if (cap_q.size() > 0)
                check($sformatf("vec%0d_tail", v), 32'(cap_q[cap_q.size() - 1].d), 32'(vt[v].exp_tail));
`ifdef AES_PAD_DEC_CHECK_EN
            check($sformatf("vec%0d_len_err", v), 32'(Len_err), 32'(err_model));
`endif
        end

        // Back-to-back encrypt frames of 1, 15 and 17 bytes under 1,0,1,0 backpressure and source gaps.
        bp_pad = '{8'h0F, 8'h01, 8'h0F};
        bp_len = '{64, 64, 80};
        add_frame(1'b1, 1, 8'h10, 1'b1);
        add_frame(1'b1, 15, 8'h20, 1'b1);
        add_frame(1'b1, 17, 8'h30, 1'b1);
        run_stream(1, 30, -1, 1'b0);
        ends.delete();
        for (int i = 0; i < cap_q.size(); i++) if (cap_q[i].l) ends.push_back(i);
        check("bp_frames", 32'(ends.size()), 32'd3);
        for (int k = 0; k < 3 && k < ends.size(); k++) begin
            check($sformatf("bp_pad%0d", k), 32'(cap_q[ends[k]].d), 32'(bp_pad[k]));
            check($sformatf("bp_len%0d", k), 32'(ends[k] - (k == 0 ? -1 : ends[k - 1])), 32'(bp_len[k]));
        end

        // Reset while the third pad byte sits in the slice, then a fresh 5-byte encrypt frame.
        add_frame(1'b1, 5, 8'h01, 1'b0);
        run_stream(0, 0, HDR + 5 + 2, 1'b0);
        check("rst_hit", 32'(rst_hit), 32'd1);
        @(negedge Clk);
        check("midrst_tvalid", 32'(M_axis_tvalid), 32'd0);
        check("midrst_tlast", 32'(M_axis_tlast), 32'd0);
`ifdef AES_PAD_DEC_CHECK_EN
        check("midrst_len_err", 32'(Len_err), 32'd0);
`endif
        err_model = 1'b0;
        Rst_n = 1'b1;
        add_frame(1'b1, 5, 8'hC0, 1'b0);
        run_stream(0, 0, -1, 1'b0);
        check("post_rst_len", 32'(cap_q.size()), 32'd64);
        if (cap_q.size() > 0) check("post_rst_tail", 32'(cap_q[cap_q.size() - 1].d), 32'h0B);

        // Random back-to-back frames of both directions under random backpressure.
        for (int f = 0; f < 8; f++) add_frame(1'($urandom), $urandom_range(0, 40), 8'h00, 1'b1);
        run_stream(2, 25, -1, 1'b0);
`ifdef AES_PAD_DEC_CHECK_EN
        check("rand_len_err", 32'(Len_err), 32'(err_model));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
